data_memory_arbiter: RTL and testbench
======================================

// Module: data_memory_arbiter
// PURPOSE
//  Shares the single-port data_memory between two requesters: port A (pipeline MEM
//  stage load/store) and port B (DMA / debug loader). Sequences each access and
//  registers read data. A has priority; a starvation counter bounds B's wait.
//  Sits between the requesters and data_memory (combinational read, posedge write).
// PARAMETERS
//  DEPTH     64  words in the attached data_memory; bounds the legal address range
//  MAX_WAIT  4   consecutive cycles B may lose to A before B is forced to win (>=1)
// PORTS
//  CLK               in   1   clock, all state on posedge
//  RST_N             in   1   asynchronous active-low reset
//  ReqA/ReqB         in   1   access request; held with Addr/WData/WE/ByteEn until Gnt
//  AddrA/AddrB       in   32  byte address; bits [1:0] ignored
//  WDataA/WDataB     in   32  write data
//  WEA/WEB           in   1   1 = write, 0 = read
//  ByteEnA/ByteEnB   in   4   byte lanes for writes (used only with DMEM_RMW_EN)
//  GntA/GntB         out  1   one-cycle pulse: access performed this cycle
//  RDataA/RDataB     out  32  registered read data, valid when RValid
//  RValidA/RValidB   out  1   one-cycle pulse, cycle after a read Gnt
//  ErrA/ErrB         out  1   one-cycle pulse with Gnt when word address >= DEPTH
//  MemAddress        out  32  to data_memory Address
//  MemWriteData      out  32  to data_memory WriteData
//  MemWriteEnable    out  1   to data_memory WriteEnable
//  MemReadData       in   32  from data_memory ReadData
// BEHAVIOUR
//  Reset: state IDLE, WaitCnt=0; Gnt*, RValid*, Err*, MemWriteEnable = 0;
//   RData* = 0; MemAddress/MemWriteData = 0. Reset mid-access aborts; no write issued.
//  FSM: IDLE, SERVE_A, SERVE_B (+ RMW_RD, RMW_WR with DMEM_RMW_EN).
//  IDLE: pick winner from ReqA/ReqB: A wins unless WaitCnt==MAX_WAIT, then B wins.
//   Next state SERVE_<winner>; neither requesting -> stay IDLE.
//  SERVE_x: MemAddress=Addr_x, MemWriteData=WData_x, MemWriteEnable=WE_x & ~Err;
//   Gnt_x=1; next state IDLE. Latency Req->Gnt = 1 cycle minimum; 2 cycles/access.
//  Reads: RData_x <= MemReadData at the Gnt edge; RValid_x=1 the following cycle.
//   RData_x holds its value until the next read by x.
//  Handshake: Req high in the Gnt cycle belongs to the granted access; a new request
//   is recognised from the cycle after Gnt. Dropping Req before Gnt = undefined.
//  WaitCnt: +1 on each IDLE decision where A wins while ReqB=1 (saturate at MAX_WAIT);
//   cleared when B is granted or ReqB=0.
//  Out of range (Addr[31:2] >= DEPTH): Gnt_x and Err_x pulse, no memory write;
//   read returns RData_x=0 with RValid_x.
//  Only one Gnt per cycle; MemWriteEnable never asserted outside a grant cycle.
// CONFIGURATION
//  DMEM_RMW_EN defined: write with ByteEn==4'hF -> single SERVE cycle as above;
//   ByteEn==0 -> Gnt with no write; other ByteEn -> RMW_RD (present address,
//   WE=0, capture MemReadData) then RMW_WR (write merged word by lane, Gnt).
//   Arbitration is not re-evaluated between RMW_RD and RMW_WR.
//  DMEM_RMW_EN undefined: ByteEn* ignored; every write is full-word, single cycle.
// TESTING
//  Reset: RST_N low mid SERVE_A write -> no write, all outputs 0 immediately.
//  A write 0x10<=0xDEADBEEF, then A read 0x10 -> GntA 1 cycle after each Req;
//   RDataA=0xDEADBEEF with RValidA cycle after read Gnt.
//  ReqA and ReqB held continuously, MAX_WAIT=4 -> grants A,A,A,A,B repeating; no
//   cycle with both Gnt high.
//  A read addr 0x100 (word 64, DEPTH=64) -> GntA+ErrA, RDataA=0, memory unchanged.
//  DMEM_RMW_EN: word 0x11223344, B write 0xAABBCCDD ByteEn=4'b0101 -> 2-cycle RMW,
//   memory = 0x11BB33DD; ByteEn=0 -> GntB, memory unchanged.
//  B alone, back-to-back reads of 0x0/0x4 -> GntB every 2nd cycle, data in order.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter in front of a single-port data memory: port A has priority,
// a wait counter bounds B's starvation. Optional byte-lane RMW writes: DMEM_RMW_EN.
module data_memory_arbiter #(
    parameter int DEPTH    = 64,
    parameter int MAX_WAIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_a,
    input  logic        i_req_b,
    input  logic [31:0] i_addr_a,
    input  logic [31:0] i_addr_b,
    input  logic [31:0] i_wdata_a,
    input  logic [31:0] i_wdata_b,
    input  logic        i_we_a,
    input  logic        i_we_b,
    input  logic [3:0]  i_byte_en_a,
    input  logic [3:0]  i_byte_en_b,
    output logic        o_gnt_a,
    output logic        o_gnt_b,
    output logic [31:0] o_rdata_a,
    output logic [31:0] o_rdata_b,
    output logic        o_rvalid_a,
    output logic        o_rvalid_b,
    output logic        o_err_a,
    output logic        o_err_b,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_mem_we,
    input  logic [31:0] i_mem_rdata
);

    localparam int WCW = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SERVE_A = 3'd1,
        S_SERVE_B = 3'd2,
        S_RMW_RD  = 3'd3,
        S_RMW_WR  = 3'd4
    } state_t;

    state_t           r_state;
    logic [WCW-1:0]   r_wait_cnt;
    logic             r_is_write;
    logic             r_err;
    logic             r_sel_b;
    logic [3:0]       r_be;

    logic             w_pick_b;
    logic [31:0]      w_addr;
    logic [31:0]      w_wdata;
    logic             w_we;
    logic [3:0]       w_be;
    logic             w_err;
    logic             w_rmw;
    logic             w_wr_en;

    function automatic logic [31:0] f_merge(input logic [31:0] old_w,
                                            input logic [31:0] new_w,
                                            input logic [3:0]  be);
        logic [31:0] m;
        m = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                m[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                m[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return m;
    endfunction

    // B wins only when A is idle or B has already lost MAX_WAIT decisions in a row
    assign w_pick_b = i_req_b & (~i_req_a | (r_wait_cnt == WCW'(MAX_WAIT)));
    assign w_addr   = w_pick_b ? i_addr_b    : i_addr_a;
    assign w_wdata  = w_pick_b ? i_wdata_b   : i_wdata_a;
    assign w_we     = w_pick_b ? i_we_b      : i_we_a;
    assign w_be     = w_pick_b ? i_byte_en_b : i_byte_en_a;
    assign w_err    = (w_addr[31:2] >= 30'(DEPTH));

`ifdef DMEM_RMW_EN
    assign w_rmw    = w_we & ~w_err & (w_be != 4'hF) & (w_be != 4'h0);
    assign w_wr_en  = w_we & ~w_err & (w_be != 4'h0);
`else
    assign w_rmw    = 1'b0;
    assign w_wr_en  = w_we & ~w_err;
`endif

    // Arbitration FSM; every memory-side and requester-side output is registered here
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= '0;
            r_is_write  <= 1'b0;
            r_err       <= 1'b0;
            r_sel_b     <= 1'b0;
            r_be        <= 4'h0;
            o_gnt_a     <= 1'b0;
            o_gnt_b     <= 1'b0;
            o_err_a     <= 1'b0;
            o_err_b     <= 1'b0;
            o_rvalid_a  <= 1'b0;
            o_rvalid_b  <= 1'b0;
            o_rdata_a   <= 32'h0;
            o_rdata_b   <= 32'h0;
            o_mem_addr  <= 32'h0;
            o_mem_wdata <= 32'h0;
            o_mem_we    <= 1'b0;
        end else begin
            o_gnt_a    <= 1'b0;
            o_gnt_b    <= 1'b0;
            o_err_a    <= 1'b0;
            o_err_b    <= 1'b0;
            o_rvalid_a <= 1'b0;
            o_rvalid_b <= 1'b0;
            o_mem_we   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!i_req_b || w_pick_b) begin
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt != WCW'(MAX_WAIT)) begin
                        r_wait_cnt <= r_wait_cnt + WCW'(1);
                    end else begin
                        r_wait_cnt <= r_wait_cnt;
                    end
                    if (i_req_a || i_req_b) begin
                        o_mem_addr  <= w_addr;
                        o_mem_wdata <= w_wdata;
                        r_is_write  <= w_we;
                        r_err       <= w_err;
                        r_sel_b     <= w_pick_b;
                        r_be        <= w_be;
                        if (w_rmw) begin
                            r_state <= S_RMW_RD;
                        end else begin
                            r_state  <= w_pick_b ? S_SERVE_B : S_SERVE_A;
                            o_gnt_a  <= ~w_pick_b;
                            o_gnt_b  <= w_pick_b;
                            o_err_a  <= ~w_pick_b & w_err;
                            o_err_b  <= w_pick_b & w_err;
                            o_mem_we <= w_wr_en;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SERVE_A: begin
                    if (!r_is_write) begin
                        o_rdata_a  <= r_err ? 32'h0 : i_mem_rdata;
                        o_rvalid_a <= 1'b1;
                    end else begin
                        o_rdata_a  <= o_rdata_a;
                    end
                    r_state <= S_IDLE;
                end
                S_SERVE_B: begin
                    if (!r_is_write) begin
                        o_rdata_b  <= r_err ? 32'h0 : i_mem_rdata;
                        o_rvalid_b <= 1'b1;
                    end else begin
                        o_rdata_b  <= o_rdata_b;
                    end
                    r_state <= S_IDLE;
                end
                S_RMW_RD: begin
                    // Address already presented with WE=0; merge the old word lane by lane
                    o_mem_wdata <= f_merge(i_mem_rdata, o_mem_wdata, r_be);
                    o_mem_we    <= 1'b1;
                    o_gnt_a     <= ~r_sel_b;
                    o_gnt_b     <= r_sel_b;
                    r_state     <= S_RMW_WR;
                end
                S_RMW_WR: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed scoreboard bench for data_memory_arbiter with a behavioural data_memory.
module tb_data_memory_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req_a, req_b, we_a, we_b;
    logic [31:0] addr_a, addr_b, wdata_a, wdata_b;
    logic [3:0]  be_a, be_b;
    logic        gnt_a, gnt_b, rvalid_a, rvalid_b, err_a, err_b, mem_we;
    logic [31:0] rdata_a, rdata_b, mem_addr, mem_wdata, mem_rdata;

    bit   [31:0] mem [64];
    logic        pl_en;
    logic [5:0]  pl_w;
    logic [31:0] pl_d;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          cyc   = 0;
    int          gnt_cyc;
    logic [31:0] qa[$];
    logic [31:0] qb[$];

    data_memory_arbiter #(.DEPTH(64), .MAX_WAIT(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_a(req_a), .i_req_b(req_b),
        .i_addr_a(addr_a), .i_addr_b(addr_b),
        .i_wdata_a(wdata_a), .i_wdata_b(wdata_b),
        .i_we_a(we_a), .i_we_b(we_b),
        .i_byte_en_a(be_a), .i_byte_en_b(be_b),
        .o_gnt_a(gnt_a), .o_gnt_b(gnt_b),
        .o_rdata_a(rdata_a), .o_rdata_b(rdata_b),
        .o_rvalid_a(rvalid_a), .o_rvalid_b(rvalid_b),
        .o_err_a(err_a), .o_err_b(err_b),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
        .i_mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // data_memory: combinational read, posedge write (word index from addr[7:2])
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (pl_en) mem[pl_w] <= pl_d;
        else if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Read-data scoreboard and per-cycle protocol checks
    always @(negedge clk) begin
        if (rst_n) begin
            if (rvalid_a) begin
                if (qa.size() == 0) chk("rvalid_a_unexpected", 32'(rvalid_a), 32'h0);
                else chk("rdata_a", rdata_a, qa.pop_front());
            end
            if (rvalid_b) begin
                if (qb.size() == 0) chk("rvalid_b_unexpected", 32'(rvalid_b), 32'h0);
                else chk("rdata_b", rdata_b, qb.pop_front());
            end
            if (gnt_a && gnt_b) chk("both_gnt", 32'h1, 32'h0);
            if (mem_we && !(gnt_a || gnt_b)) chk("we_no_gnt", 32'h1, 32'h0);
            if ((err_a || err_b) && mem_we) chk("we_on_err", 32'h1, 32'h0);
        end
    end

    task automatic preload(input logic [5:0] w, input logic [31:0] d);
        pl_en = 1'b1; pl_w = w; pl_d = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic acc(input bit pb, input logic [31:0] addr, input logic [31:0] wd,
                       input bit we, input logic [3:0] be, input bit exp_err,
                       input int exp_lat, input logic [31:0] exp_rd);
        int n;
        bit g;
        if (pb) begin
            req_b = 1'b1; addr_b = addr; wdata_b = wd; we_b = we; be_b = be;
            if (!we) qb.push_back(exp_rd);
        end else begin
            req_a = 1'b1; addr_a = addr; wdata_a = wd; we_a = we; be_a = be;
            if (!we) qa.push_back(exp_rd);
        end
        n = 0; g = 1'b0;
        while (!g && n < 8) begin
            @(negedge clk);
            n++;
            g = pb ? gnt_b : gnt_a;
        end
        chk("gnt_seen", 32'(g), 32'h1);
        if (g) begin
            gnt_cyc = cyc;
            chk("latency", 32'(n), 32'(exp_lat));
            chk("err", 32'(pb ? err_b : err_a), 32'(exp_err));
        end
        @(posedge clk); #1;
        if (pb) req_b = 1'b0; else req_a = 1'b0;
    endtask

    initial begin
        string seq;
        int    g1;
        int    n;
        rst_n = 1'b0; pl_en = 1'b0; pl_w = 6'd0; pl_d = 32'h0;
        req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
        addr_a = 32'h0; addr_b = 32'h0; wdata_a = 32'h0; wdata_b = 32'h0;
        be_a = 4'hF; be_b = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", {30'h0, gnt_a, gnt_b}, 32'h0);
        chk("rst_rvalid_err_we", {27'h0, rvalid_a, rvalid_b, err_a, err_b, mem_we}, 32'h0);
        chk("rst_rdata_a", rdata_a, 32'h0);
        chk("rst_rdata_b", rdata_b, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        preload(6'd4, 32'h12345678);
        preload(6'd0, 32'hA0A0A0A0);
        preload(6'd1, 32'hB1B1B1B1);
        preload(6'd8, 32'h11223344);

        // Reset asserted during the SERVE_A cycle of a write
        req_a = 1'b1; addr_a = 32'h10; wdata_a = 32'hCAFEF00D; we_a = 1'b1;
        n = 0;
        while (!gnt_a && n < 8) begin @(negedge clk); n++; end
        chk("rstmid_gnt", 32'(gnt_a), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_outs", {28'h0, gnt_a, gnt_b, mem_we, rvalid_a}, 32'h0);
        chk("rstmid_addr", mem_addr, 32'h0);
        chk("rstmid_wdata", mem_wdata, 32'h0);
        @(posedge clk); #1;
        chk("rstmid_mem", mem[4], 32'h12345678);
        req_a = 1'b0; we_a = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // A write then read back
        acc(1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 4'hF, 1'b0, 2, 32'h0);
        chk("wr_mem4", mem[4], 32'hDEADBEEF);
        acc(1'b0, 32'h10, 32'h0, 1'b0, 4'hF, 1'b0, 2, 32'hDEADBEEF);

        // Out of range (word 64): error pulse, zero data, memory untouched
        acc(1'b0, 32'h100, 32'h0, 1'b0, 4'hF, 1'b1, 2, 32'h0);
        acc(1'b0, 32'h100, 32'h55555555, 1'b1, 4'hF, 1'b1, 2, 32'h0);
        chk("oor_mem0", mem[0], 32'hA0A0A0A0);
        acc(1'b0, 32'h0FC, 32'h0, 1'b0, 4'hF, 1'b0, 2, 32'h0);

        // Both requesting continuously: A,A,A,A,B repeating
        req_a = 1'b1; addr_a = 32'h40; wdata_a = 32'h1; we_a = 1'b1; be_a = 4'hF;
        req_b = 1'b1; addr_b = 32'h44; wdata_b = 32'h2; we_b = 1'b1; be_b = 4'hF;
        seq = "";
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt_a) seq = {seq, "A"};
            if (gnt_b) seq = {seq, "B"};
        end
        @(posedge clk); #1;
        req_a = 1'b0; req_b = 1'b0;
        n_cmp++;
        assert (seq == "AAAABAAAAB") else begin
            n_mis++;
            $error("FAIL arb_seq: observed %s expected AAAABAAAAB", seq);
        end
        chk("arb_mem_a", mem[16], 32'h1);
        chk("arb_mem_b", mem[17], 32'h2);

        // B alone, back-to-back reads
        acc(1'b1, 32'h0, 32'h0, 1'b0, 4'hF, 1'b0, 2, 32'hA0A0A0A0);
        g1 = gnt_cyc;
        acc(1'b1, 32'h4, 32'h0, 1'b0, 4'hF, 1'b0, 2, 32'hB1B1B1B1);
        chk("b2b_spacing", 32'(gnt_cyc - g1), 32'd2);

        // Partial byte-lane write, then empty-lane write
`ifdef DMEM_RMW_EN
        acc(1'b1, 32'h20, 32'hAABBCCDD, 1'b1, 4'b0101, 1'b0, 3, 32'h0);
        chk("rmw_mem", mem[8], 32'h11BB33DD);
        acc(1'b1, 32'h20, 32'h99999999, 1'b1, 4'b0000, 1'b0, 2, 32'h0);
        chk("be0_mem", mem[8], 32'h11BB33DD);
`else
        acc(1'b1, 32'h20, 32'hAABBCCDD, 1'b1, 4'b0101, 1'b0, 2, 32'h0);
        chk("fullwr_mem", mem[8], 32'hAABBCCDD);
        acc(1'b1, 32'h20, 32'h99999999, 1'b1, 4'b0000, 1'b0, 2, 32'h0);
        chk("be0_mem", mem[8], 32'h99999999);
`endif
        acc(1'b1, 32'h20, 32'h0, 1'b0, 4'hF, 1'b0, 2, mem[8]);
        chk("rdata_a_hold", rdata_a, 32'h0);

        repeat (4) @(posedge clk);
        #1;
        chk("qa_drained", 32'(qa.size()), 32'h0);
        chk("qb_drained", 32'(qb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
